// File: rtl/connect4_pkg.sv
// Shared types and board geometry for the Connect-4 datapath.
package connect4_pkg;

   localparam int NUM_COLS = 7;
   localparam int NUM_ROWS = 6;
   localparam int COL_W    = 3;
   localparam int ROW_W    = 3;

   typedef enum logic {
      PLAYER_LOCAL   = 1'b0,
      PLAYER_ARDUINO = 1'b1
   } player_t;

   typedef enum logic [1:0] {
      WAIT_MOVE = 2'd0,
      CHECK     = 2'd1,
      WRITE     = 2'd2,
      DONE      = 2'd3
   } arb_state_t;

   // The opponent of a given player.
   function automatic player_t other_player(input player_t p);
      return (p == PLAYER_LOCAL) ? PLAYER_ARDUINO : PLAYER_LOCAL;
   endfunction

endpackage

// File: rtl/jugada_arbiter_if.sv
// Board-write port: the arbiter drives one piece at a time, the board
// memory accepts it with wr_ready.
interface jugada_arbiter_if import connect4_pkg::*; ();

   logic             wr_valid;
   logic             wr_ready;
   logic [COL_W-1:0] wr_col;
   logic [ROW_W-1:0] wr_row;
   logic             wr_player;

   modport master (output wr_valid, wr_col, wr_row, wr_player, input wr_ready);
   modport slave  (input wr_valid, wr_col, wr_row, wr_player, output wr_ready);

endinterface

// File: rtl/turn_timer.sv
// Per-turn move timer. Counts while enabled, holds at the last count and
// flags expiry there; clear has priority over counting.
module turn_timer #(
   parameter int  TURN_CYCLES = 500_000_000,
   localparam int TW          = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [TW-1:0] LAST = TW'(TURN_CYCLES - 1);

   logic [TW-1:0] cnt;

   // Count up while enabled, saturating at the expiry value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && (cnt != LAST))
         cnt <= cnt + 1'b1;
   end

   assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/jugada_arbiter.sv
// Connect-4 turn scheduler: arbitrates the single board-write port between
// the local button player and the Arduino player, enforces turn order,
// tracks column heights, rejects illegal moves and forfeits slow turns.
module jugada_arbiter import connect4_pkg::*; #(
   parameter int NUM_COLS     = connect4_pkg::NUM_COLS,
   parameter int NUM_ROWS     = connect4_pkg::NUM_ROWS,
   parameter int TURN_CYCLES  = 500_000_000,
   parameter bit FIRST_PLAYER = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [COL_W-1:0] col_local,
   input  logic             local_valida_jugada,
   input  logic [COL_W-1:0] col_arduino,
   input  logic             arduino_valida_jugada,
   input  logic             game_over,
   input  logic             new_game,
   jugada_arbiter_if.master wr,
   output logic             turn,
   output logic             reject_turn,
   output logic             reject_col,
   output logic             reject_full,
   output logic             turn_timeout,
   output logic             board_full
);

   localparam int HW = $clog2(NUM_ROWS + 1);
   localparam int MW = $clog2(NUM_COLS * NUM_ROWS + 1);
   localparam logic [HW-1:0] H_FULL  = HW'(NUM_ROWS);
   localparam logic [MW-1:0] M_LAST  = MW'(NUM_COLS * NUM_ROWS - 1);
   localparam player_t       P_FIRST = player_t'(FIRST_PLAYER);

   arb_state_t       state, state_d;
   player_t          turn_q;
   logic [COL_W-1:0] col_q;
   logic [HW-1:0]    height [NUM_COLS];
   logic [MW-1:0]    move_cnt;
   logic             board_full_q;

   logic             wr_valid_q, wr_valid_d;
   logic [COL_W-1:0] wr_col_q;
   logic [ROW_W-1:0] wr_row_q;
   player_t          wr_player_q;

   logic rej_turn_q, rej_col_q, rej_full_q, tout_q;
   logic rej_turn_d, rej_col_d, rej_full_d, tout_d;

   logic             req_cur, req_oth;
   logic [COL_W-1:0] col_cur, col_idx;
   logic             col_ok, col_full;
   logic             hs, cap, load_wr, flip, commit, tmr_clr, tmr_en, tmr_exp;

   // Requests seen from the point of view of whoever holds the turn.
   assign req_cur = (turn_q == PLAYER_LOCAL) ? local_valida_jugada : arduino_valida_jugada;
   assign req_oth = (turn_q == PLAYER_LOCAL) ? arduino_valida_jugada : local_valida_jugada;
   assign col_cur = (turn_q == PLAYER_LOCAL) ? col_local : col_arduino;

   // Out-of-range columns are steered to index 0 so the height lookup never
   // leaves the array; the result is ignored in that case anyway.
   assign col_ok   = 32'(col_q) < NUM_COLS;
   assign col_idx  = col_ok ? col_q : '0;
   assign col_full = (height[col_idx] == H_FULL);

   assign hs     = wr_valid_q && wr.wr_ready;
   assign tmr_en = (state == WAIT_MOVE) || (state == CHECK);

   turn_timer #(.TURN_CYCLES(TURN_CYCLES)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clr),
      .enable (tmr_en),
      .expire (tmr_exp)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= WAIT_MOVE;
      else       state <= state_d;
   end

   // Next state plus the next values of every registered output.
   always_comb begin
      state_d    = state;
      cap        = 1'b0;
      load_wr    = 1'b0;
      flip       = 1'b0;
      commit     = 1'b0;
      tmr_clr    = 1'b0;
      wr_valid_d = wr_valid_q;
      rej_turn_d = req_oth;   // the non-turn source is refused in every state
      rej_col_d  = 1'b0;
      rej_full_d = 1'b0;
      tout_d     = 1'b0;

      case (state)
         WAIT_MOVE: begin
            if (game_over) begin
               state_d = DONE;
               if (req_cur) rej_turn_d = 1'b1;
            end else if (tmr_exp) begin
               // The turn is forfeited; a request landing on the same cycle
               // belongs to a player who no longer holds the turn.
               tout_d  = 1'b1;
               flip    = 1'b1;
               tmr_clr = 1'b1;
               if (req_cur) rej_turn_d = 1'b1;
            end else if (req_cur) begin
               cap     = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (req_cur) rej_turn_d = 1'b1;
            if (game_over) begin
               state_d = DONE;
            end else if (!col_ok) begin
               rej_col_d = 1'b1;
               state_d   = WAIT_MOVE;
            end else if (col_full) begin
               rej_full_d = 1'b1;
               state_d    = WAIT_MOVE;
            end else begin
               load_wr    = 1'b1;
               wr_valid_d = 1'b1;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            if (req_cur) rej_turn_d = 1'b1;
            if (hs) begin
               wr_valid_d = 1'b0;
               commit     = 1'b1;
               flip       = 1'b1;
               tmr_clr    = 1'b1;
               state_d    = ((move_cnt == M_LAST) || game_over) ? DONE : WAIT_MOVE;
            end
         end
         DONE: begin
            if (req_cur) rej_turn_d = 1'b1;
         end
      endcase

      // A new game abandons whatever was in progress, including a pending write.
      if (new_game) begin
         state_d    = WAIT_MOVE;
         cap        = 1'b0;
         load_wr    = 1'b0;
         flip       = 1'b0;
         commit     = 1'b0;
         tmr_clr    = 1'b1;
         wr_valid_d = 1'b0;
         rej_turn_d = 1'b0;
         rej_col_d  = 1'b0;
         rej_full_d = 1'b0;
         tout_d     = 1'b0;
      end
   end

   // Turn owner, captured column, move counter and board-full flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         turn_q       <= P_FIRST;
         col_q        <= '0;
         move_cnt     <= '0;
         board_full_q <= 1'b0;
      end else if (new_game) begin
         turn_q       <= P_FIRST;
         move_cnt     <= '0;
         board_full_q <= 1'b0;
      end else begin
         if (cap)  col_q  <= col_cur;
         if (flip) turn_q <= other_player(turn_q);
         if (commit) begin
            move_cnt <= move_cnt + 1'b1;
            if (move_cnt == M_LAST) board_full_q <= 1'b1;
         end
      end
   end

   // Column heights; saturate at a full column.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_COLS; i++) height[i] <= '0;
      end else if (new_game) begin
         for (int i = 0; i < NUM_COLS; i++) height[i] <= '0;
      end else if (commit && !col_full) begin
         height[col_idx] <= height[col_idx] + 1'b1;
      end
   end

   // Registered write port and status pulses; write fields hold through WRITE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_valid_q  <= 1'b0;
         wr_col_q    <= '0;
         wr_row_q    <= '0;
         wr_player_q <= PLAYER_LOCAL;
         rej_turn_q  <= 1'b0;
         rej_col_q   <= 1'b0;
         rej_full_q  <= 1'b0;
         tout_q      <= 1'b0;
      end else begin
         wr_valid_q <= wr_valid_d;
         rej_turn_q <= rej_turn_d;
         rej_col_q  <= rej_col_d;
         rej_full_q <= rej_full_d;
         tout_q     <= tout_d;
         if (load_wr) begin
            wr_col_q    <= col_q;
            wr_row_q    <= ROW_W'(height[col_idx]);
            wr_player_q <= turn_q;
         end
      end
   end

   assign wr.wr_valid  = wr_valid_q;
   assign wr.wr_col    = wr_col_q;
   assign wr.wr_row    = wr_row_q;
   assign wr.wr_player = wr_player_q;

   assign turn         = turn_q;
   assign reject_turn  = rej_turn_q;
   assign reject_col   = rej_col_q;
   assign reject_full  = rej_full_q;
   assign turn_timeout = tout_q;
   assign board_full   = board_full_q;

endmodule

// File: doc/jugada_arbiter.md
# jugada_arbiter

Turn scheduler for the Connect-4 game. It shares the single board-write port between the local button player and the Arduino player, whose moves arrive as `col_arduino`/`arduino_valida_jugada` from the SPI slave. It enforces turn order, tracks column heights, rejects illegal moves and passes the turn on timeout. It sits between the two move sources and the board memory / win detector.

## Interface
- `NUM_COLS`, 7: board columns.
- `NUM_ROWS`, 6: board rows; row 0 is the bottom row.
- `TURN_CYCLES`, 500_000_000: per-turn move time limit in `clk` cycles (10 s at 50 MHz).
- `FIRST_PLAYER`, 0: player who moves first (0 = local, 1 = Arduino).

Ports:
- `clk` in 1: FPGA system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `col_local` in 3: local player column.
- `local_valida_jugada` in 1: 1-cycle pulse, local move request.
- `col_arduino` in 3: Arduino column, from the SPI slave.
- `arduino_valida_jugada` in 1: 1-cycle pulse, Arduino move request.
- `game_over` in 1: level signal from the win detector.
- `new_game` in 1: 1-cycle pulse that restarts the game.
- `wr_valid` out 1: board write request.
- `wr_ready` in 1: board accepts the write.
- `wr_col` out 3: column to write.
- `wr_row` out 3: row to write.
- `wr_player` out 1: player who owns the piece.
- `turn` out 1: current player.
- `reject_turn` out 1: 1-cycle pulse; request came from the wrong player or arrived at the wrong time.
- `reject_col` out 1: 1-cycle pulse; column ≥ `NUM_COLS`.
- `reject_full` out 1: 1-cycle pulse; column is full.
- `turn_timeout` out 1: 1-cycle pulse; the turn was forfeited.
- `board_full` out 1: level; all `NUM_COLS*NUM_ROWS` cells are filled.

## Operation
- **States:** WAIT_MOVE, CHECK, WRITE, DONE.
- **Reset values:**
  - State is WAIT_MOVE and `turn` is `FIRST_PLAYER`.
  - All column heights, the move counter and the timer are 0.
  - All outputs are 0, except `turn`.
- **Capture:**
  - In WAIT_MOVE, a valid pulse from the source equal to `turn` latches that column and moves the FSM to CHECK.
  - A pulse from the other source, in any state, produces `reject_turn` and is not captured.
  - A pulse from the `turn` source outside WAIT_MOVE also produces `reject_turn`.
  - If both sources pulse in the same cycle, the `turn` source is accepted and the other is rejected.
- **CHECK (1 cycle):**
  - Column ≥ `NUM_COLS`: `reject_col`, return to WAIT_MOVE.
  - Otherwise, `height[col] == NUM_ROWS`: `reject_full`, return to WAIT_MOVE.
  - Otherwise: `wr_row = height[col]`, `wr_col = col`, `wr_player = turn`, go to WRITE.
  - The timer is not reset by a rejection.
- **WRITE:**
  - `wr_valid` is high; `wr_col`, `wr_row` and `wr_player` stay stable until `wr_ready`.
  - On `wr_valid && wr_ready`: `height[col]` increments, the move counter increments, `turn` flips, and the timer clears.
  - Next state is DONE if the move counter reaches 42 (`board_full` goes high); otherwise WAIT_MOVE.
- **Timeout:**
  - Applies in WAIT_MOVE only.
  - When the timer equals `TURN_CYCLES-1`: `turn_timeout` pulses, `turn` flips, and the timer clears.
  - The timer counts only in WAIT_MOVE and CHECK.
- **Game over:** `game_over` high in WAIT_MOVE or CHECK forces DONE. In WRITE, the pending write completes first, then the FSM goes to DONE.
- **DONE:** all requests produce `reject_turn`; no timeouts occur.
- **`new_game` (any state, highest priority after `reset`):**
  - Resets heights, move counter, timer, `turn` and `board_full`.
  - State becomes WAIT_MOVE.
  - An in-flight WRITE is abandoned and `wr_valid` drops the next cycle.
- **Width rules:**
  - Heights are `$clog2(NUM_ROWS+1)` bits and saturate at `NUM_ROWS`.
  - The timer is `$clog2(TURN_CYCLES)` bits.

## Timing
- All outputs are registered.
- Accepted pulse at cycle N: CHECK at N+1, `wr_valid` high at N+2.
- Reject pulses are asserted for exactly one cycle: N+1 for `reject_turn`, N+2 for `reject_col`/`reject_full`.
- With `wr_ready` tied high, the handshake completes at N+2, `turn` flips at N+3, and a new move can be captured from N+3.
- `turn_timeout` and the `turn` flip appear on the same edge.

## Structure
- `connect4_pkg` holds:
  - `NUM_COLS`, `NUM_ROWS`;
  - `player_t` (`PLAYER_LOCAL`=0, `PLAYER_ARDUINO`=1);
  - the `arb_state_t` enum.
- Sub-module `turn_timer` holds the timer: clear / enable / expire, parameterised by `TURN_CYCLES`.
- Column heights live in a `NUM_COLS`-entry register array inside the arbiter.

## Test plan
- Reset, then local col 3 → `wr_col`=3, `wr_row`=0, `wr_player`=0; with `wr_ready` held high, `turn` becomes 1.
- While `turn`=1, local pulse col 2 → `reject_turn`, no write. Arduino col 2 → write row 0, `wr_player`=1.
- Six alternating moves into col 0, then a seventh to col 0 → `reject_full`; `turn` unchanged; col 1 is then accepted.
- Current player requests col 7 → `reject_col`. Both sources pulse in the same cycle → current player accepted, other `reject_turn`.
- `TURN_CYCLES`=16, no input → `turn_timeout` at cycle 16, `turn` flips. `wr_ready` held low 5 cycles → `wr_*` stable throughout.
- Fill all 42 cells → `board_full`=1, DONE. `new_game` mid-WRITE → `wr_valid`=0 next cycle, heights 0, `turn`=`FIRST_PLAYER`. `game_over` → further requests rejected.
